mef_espera: RTL
===============

# mef_espera

Parametrised multicycle control state machine for the RV32I core. It generalises the existing controller with a memory ready/valid handshake that supports variable wait states, and a programmable memory timeout. It also adds an illegal-opcode trap state, a retired-instruction counter and an exposed state code. It sits between the instruction register (`op`) and the datapath multiplexers and enables, and drives the unified instruction/data memory handshake.

## Interface
- `ESPERA_MAX`, default 15: maximum wait cycles allowed for `mem_listo` per access; 0 disables the timeout.
- `ANCHO_CONT`, default 32: width of the retired-instruction counter.
- `clk` in 1: clock; all state changes on the rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `op` in 7: opcode from the instruction register.
- `mem_listo` in 1: memory completes the current access this cycle.
- `mem_valido` out 1: memory request active.
- `esc_pc`, `branch`, `sel_dir`, `esc_mem`, `esc_inst`, `esc_reg` out 1 each: datapath enables and selects.
- `sel_inmediato` out 3: immediate format; 0=I, 1=S, 2=B, 3=U, 4=J.
- `modo_alu` out 2: 0=add, 1=funct3/funct7, 2=branch compare.
- `sel_op1` out 2: 0=PC, 1=rs1, 2=pc_ant, 3=zero.
- `sel_op2` out 2: 0=rs2, 1=immediate, 2=constant 4.
- `sel_y` out 2: write-back source; 0=ALU, 1=memory data, 2=PC.
- `estado` out 3: current state code.
- `error` out 1: trap active.
- `causa_error` out 2: 0=none, 1=illegal opcode, 2=timeout.
- `retirada` out 1: one-cycle pulse when an instruction retires.
- `contador_retiradas` out ANCHO_CONT: count of retired instructions.

## Operation
- States and codes:
  - INICIO=0, BUSQUEDA=1, DECODIFICA=2, EJECUTA=3, MEMORIA=4, ESCRITURA=5, ERROR=7.
  - Outputs not listed for a state are 0.
- INICIO: all outputs 0; next state is BUSQUEDA.
- BUSQUEDA:
  - `mem_valido`=1, `sel_dir`=0.
  - When `mem_listo`=1: `esc_inst`=1, `esc_pc`=1, `sel_op1`=0, `sel_op2`=2, `modo_alu`=0; next state is DECODIFICA.
  - Otherwise the FSM stays in BUSQUEDA.
- DECODIFICA:
  - Registers `op` into `op_r`.
  - Precomputes the branch target: `sel_op1`=2, `sel_op2`=1, `sel_inmediato`=2.
  - Opcodes 3, 19, 23, 35, 51, 55, 99, 103 and 111 go to EJECUTA.
  - Any other opcode goes to ERROR with `causa_error`=1.
- EJECUTA, outputs by `op_r`:
  - 3 (load) and 35 (store): op1=1, op2=1, imm=0 or 1 respectively, alu=0; next MEMORIA.
  - 51: op1=1, op2=0, alu=1; next ESCRITURA.
  - 19: op1=1, op2=1, imm=0, alu=1; next ESCRITURA.
  - 23: op1=2, op2=1, imm=3, alu=0; next ESCRITURA.
  - 55: op1=3, op2=1, imm=3, alu=0; next ESCRITURA.
  - 99: op1=1, op2=0, alu=2, `branch`=1; next BUSQUEDA and retires.
  - 111: `esc_reg`=1, `sel_y`=2, `esc_pc`=1, op1=2, op2=1, imm=4, alu=0; next BUSQUEDA and retires.
  - 103: same as 111 except op1=1 and imm=0.
- MEMORIA:
  - Holds the EJECUTA operand selections; `mem_valido`=1, `sel_dir`=1.
  - Store: `esc_mem`=1. On `mem_listo` the next state is BUSQUEDA and the instruction retires.
  - Load: on `mem_listo` the next state is ESCRITURA.
- ESCRITURA:
  - Holds the EJECUTA operand selections; `esc_reg`=1.
  - `sel_y`=1 for a load, 0 otherwise.
  - Next state is BUSQUEDA and the instruction retires.
- Timeout:
  - The wait counter clears on entry to BUSQUEDA or MEMORIA and counts each cycle with `mem_listo`=0.
  - If it reaches `ESPERA_MAX` (and `ESPERA_MAX`≠0), the next state is ERROR with `causa_error`=2.
  - `mem_listo`=1 in the same cycle the count reaches `ESPERA_MAX` wins: the access completes and there is no error.
- ERROR: `error`=1; all enables and `mem_valido` are 0; `causa_error` holds. The FSM leaves only on reset.
- Retirement: `retirada` pulses in the cycle the retiring transition is taken. `contador_retiradas` increments on the same edge and wraps to 0 modulo 2^ANCHO_CONT.

## Timing
- Reset:
  - Asserting `reset` immediately forces INICIO, `causa_error`=0, counters=0 and all outputs 0, including mid-access.
  - The first BUSQUEDA occurs one cycle after `reset` is released.
- Outputs:
  - Moore outputs decode from the state register.
  - The BUSQUEDA completion enables and MEMORIA completion use `mem_listo` in the same cycle (Mealy).
- Latency in cycles with zero wait states (`mem_listo` held at 1):
  - Branch, JAL, JALR: 3.
  - R, I-ALU, LUI, AUIPC, store: 4.
  - Load: 5.
  - Each wait cycle adds 1.
- `op` is sampled only in DECODIFICA; changes in any other state have no effect.

## Test plan
- Reset, then `mem_listo`=1 and `op`=51: states 0→1→2→3→5→1; `esc_reg`=1 only in ESCRITURA; `retirada` pulses once; counter=1.
- `op`=3 with `mem_listo` low for 3 cycles in MEMORIA: load takes 8 cycles; ESCRITURA has `sel_y`=1; no error.
- `op`=35, then `op`=111: store asserts `esc_mem`=1 only in MEMORIA. JAL asserts `esc_pc`=`esc_reg`=1 with `sel_y`=2 and `sel_inmediato`=4 in EJECUTA; counter=2.
- `op`=7'h7F: DECODIFICA→ERROR, `error`=1, `causa_error`=1; stays in ERROR for 20 cycles; reset returns the FSM to INICIO.
- `ESPERA_MAX`=4, `mem_listo`=0 in BUSQUEDA: ERROR after 4 wait cycles with `causa_error`=2. Repeat with `mem_listo`=1 on the 4th wait cycle: no error.
- `ANCHO_CONT`=3, 9 consecutive `op`=99 retires: counter reads 1; `reset` asserted mid-MEMORIA forces all outputs to 0 immediately.

Source files
------------

// File: rtl/mef_espera.sv
// ---------------------------------------------------------------------------
// mef_espera
// Multicycle control FSM for the RV32I core with a ready/valid memory
// handshake, a programmable memory timeout, an illegal-opcode trap state,
// a retired-instruction counter and an exposed state code.
//
// Ports
//   clk                 : clock, rising edge active
//   reset               : asynchronous, active-high reset
//   op[6:0]             : opcode from the instruction register
//   mem_listo           : memory completes the current access this cycle
//   mem_valido          : memory request active
//   esc_pc, branch      : PC write enable, conditional branch enable
//   sel_dir             : memory address select (0=PC, 1=ALU result)
//   esc_mem, esc_inst   : data memory write, instruction register write
//   esc_reg             : register file write enable
//   sel_inmediato[2:0]  : immediate format (0=I,1=S,2=B,3=U,4=J)
//   modo_alu[1:0]       : 0=add, 1=funct3/funct7, 2=branch compare
//   sel_op1[1:0]        : 0=PC, 1=rs1, 2=pc_ant, 3=zero
//   sel_op2[1:0]        : 0=rs2, 1=immediate, 2=constant 4
//   sel_y[1:0]          : write-back source (0=ALU, 1=memory, 2=PC)
//   estado[2:0]         : current state code
//   error               : trap active
//   causa_error[1:0]    : 0=none, 1=illegal opcode, 2=timeout
//   retirada            : one-cycle pulse when an instruction retires
//   contador_retiradas  : count of retired instructions (wraps)
// ---------------------------------------------------------------------------
module mef_espera #(
  parameter int ESPERA_MAX = 15,
  parameter int ANCHO_CONT = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [6:0]            op,
  input  logic                  mem_listo,
  output logic                  mem_valido,
  output logic                  esc_pc,
  output logic                  branch,
  output logic                  sel_dir,
  output logic                  esc_mem,
  output logic                  esc_inst,
  output logic                  esc_reg,
  output logic [2:0]            sel_inmediato,
  output logic [1:0]            modo_alu,
  output logic [1:0]            sel_op1,
  output logic [1:0]            sel_op2,
  output logic [1:0]            sel_y,
  output logic [2:0]            estado,
  output logic                  error,
  output logic [1:0]            causa_error,
  output logic                  retirada,
  output logic [ANCHO_CONT-1:0] contador_retiradas
);

  localparam logic [6:0] OP_LOAD   = 7'd3;
  localparam logic [6:0] OP_IMM    = 7'd19;
  localparam logic [6:0] OP_AUIPC  = 7'd23;
  localparam logic [6:0] OP_STORE  = 7'd35;
  localparam logic [6:0] OP_REG    = 7'd51;
  localparam logic [6:0] OP_LUI    = 7'd55;
  localparam logic [6:0] OP_BRANCH = 7'd99;
  localparam logic [6:0] OP_JALR   = 7'd103;
  localparam logic [6:0] OP_JAL    = 7'd111;

  localparam logic [1:0] CAUSA_ILEGAL  = 2'd1;
  localparam logic [1:0] CAUSA_TIMEOUT = 2'd2;

  // The wait counter only needs to hold 0..ESPERA_MAX-1: the access that
  // would push it to ESPERA_MAX traps instead of counting further.
  localparam int CW = (ESPERA_MAX < 2) ? 1 : $clog2(ESPERA_MAX);
  localparam logic [CW-1:0] LIMITE = (ESPERA_MAX == 0) ? '0 : CW'(ESPERA_MAX - 1);

  typedef enum logic [2:0] {
    INICIO     = 3'd0,
    BUSQUEDA   = 3'd1,
    DECODIFICA = 3'd2,
    EJECUTA    = 3'd3,
    MEMORIA    = 3'd4,
    ESCRITURA  = 3'd5,
    ERROR      = 3'd7
  } estado_t;

  estado_t               estado_q, estado_d;
  logic [6:0]            op_r;
  logic [1:0]            causa_q, causa_d;
  logic [CW-1:0]         espera_q;
  logic [ANCHO_CONT-1:0] cont_q;
  logic                  agotado;

  logic [1:0] op1_x, op2_x, alu_x;
  logic [2:0] imm_x;

  // A wait cycle that would bring the count to ESPERA_MAX is the timeout;
  // a ready memory in that same cycle still completes the access.
  assign agotado = (ESPERA_MAX != 0) && !mem_listo && (espera_q == LIMITE);

  // Operand selections of the latched instruction. EJECUTA drives them and
  // MEMORIA/ESCRITURA keep driving them so the ALU result stays stable.
  always_comb begin
    op1_x = 2'd0;
    op2_x = 2'd0;
    imm_x = 3'd0;
    alu_x = 2'd0;
    case (op_r)
      OP_LOAD:   begin op1_x = 2'd1; op2_x = 2'd1; imm_x = 3'd0; alu_x = 2'd0; end
      OP_STORE:  begin op1_x = 2'd1; op2_x = 2'd1; imm_x = 3'd1; alu_x = 2'd0; end
      OP_REG:    begin op1_x = 2'd1; op2_x = 2'd0; alu_x = 2'd1; end
      OP_IMM:    begin op1_x = 2'd1; op2_x = 2'd1; imm_x = 3'd0; alu_x = 2'd1; end
      OP_AUIPC:  begin op1_x = 2'd2; op2_x = 2'd1; imm_x = 3'd3; alu_x = 2'd0; end
      OP_LUI:    begin op1_x = 2'd3; op2_x = 2'd1; imm_x = 3'd3; alu_x = 2'd0; end
      OP_BRANCH: begin op1_x = 2'd1; op2_x = 2'd0; alu_x = 2'd2; end
      OP_JAL:    begin op1_x = 2'd2; op2_x = 2'd1; imm_x = 3'd4; alu_x = 2'd0; end
      OP_JALR:   begin op1_x = 2'd1; op2_x = 2'd1; imm_x = 3'd0; alu_x = 2'd0; end
      default:   ;
    endcase
  end

  // State register plus the bookkeeping that rides along with it: the trap
  // cause, the opcode latched during decode, the memory wait counter and the
  // retired-instruction counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      estado_q <= INICIO;
      causa_q  <= 2'd0;
      op_r     <= 7'd0;
      espera_q <= '0;
      cont_q   <= '0;
    end else begin
      estado_q <= estado_d;
      causa_q  <= causa_d;
      if (estado_q == DECODIFICA)
        op_r <= op;
      // Any state change clears the counter, which covers entry into both
      // waiting states.
      if (estado_d != estado_q)
        espera_q <= '0;
      else if ((estado_q == BUSQUEDA || estado_q == MEMORIA) && !mem_listo &&
               espera_q != LIMITE)
        espera_q <= espera_q + 1'b1;
      if (retirada)
        cont_q <= cont_q + 1'b1;
    end
  end

  // Next-state and output decode. Everything is Moore from the state
  // register except the fetch completion enables and the memory completion,
  // which react to mem_listo in the same cycle.
  always_comb begin
    estado_d      = estado_q;
    causa_d       = causa_q;
    mem_valido    = 1'b0;
    esc_pc        = 1'b0;
    branch        = 1'b0;
    sel_dir       = 1'b0;
    esc_mem       = 1'b0;
    esc_inst      = 1'b0;
    esc_reg       = 1'b0;
    sel_inmediato = 3'd0;
    modo_alu      = 2'd0;
    sel_op1       = 2'd0;
    sel_op2       = 2'd0;
    sel_y         = 2'd0;
    error         = 1'b0;
    retirada      = 1'b0;

    case (estado_q)
      INICIO: begin
        estado_d = BUSQUEDA;
      end

      BUSQUEDA: begin
        mem_valido = 1'b1;
        if (mem_listo) begin
          esc_inst = 1'b1;
          esc_pc   = 1'b1;
          sel_op1  = 2'd0;
          sel_op2  = 2'd2;
          modo_alu = 2'd0;
          estado_d = DECODIFICA;
        end else if (agotado) begin
          estado_d = ERROR;
          causa_d  = CAUSA_TIMEOUT;
        end
      end

      DECODIFICA: begin
        sel_op1       = 2'd2;
        sel_op2       = 2'd1;
        sel_inmediato = 3'd2;
        case (op)
          OP_LOAD, OP_IMM, OP_AUIPC, OP_STORE, OP_REG,
          OP_LUI, OP_BRANCH, OP_JALR, OP_JAL: estado_d = EJECUTA;
          default: begin
            estado_d = ERROR;
            causa_d  = CAUSA_ILEGAL;
          end
        endcase
      end

      EJECUTA: begin
        sel_op1       = op1_x;
        sel_op2       = op2_x;
        sel_inmediato = imm_x;
        modo_alu      = alu_x;
        case (op_r)
          OP_LOAD, OP_STORE:                 estado_d = MEMORIA;
          OP_REG, OP_IMM, OP_AUIPC, OP_LUI:  estado_d = ESCRITURA;
          OP_BRANCH: begin
            branch   = 1'b1;
            retirada = 1'b1;
            estado_d = BUSQUEDA;
          end
          OP_JAL, OP_JALR: begin
            esc_reg  = 1'b1;
            sel_y    = 2'd2;
            esc_pc   = 1'b1;
            retirada = 1'b1;
            estado_d = BUSQUEDA;
          end
          default: begin
            estado_d = ERROR;
            causa_d  = CAUSA_ILEGAL;
          end
        endcase
      end

      MEMORIA: begin
        sel_op1       = op1_x;
        sel_op2       = op2_x;
        sel_inmediato = imm_x;
        modo_alu      = alu_x;
        mem_valido    = 1'b1;
        sel_dir       = 1'b1;
        esc_mem       = (op_r == OP_STORE);
        if (mem_listo) begin
          if (op_r == OP_STORE) begin
            retirada = 1'b1;
            estado_d = BUSQUEDA;
          end else begin
            estado_d = ESCRITURA;
          end
        end else if (agotado) begin
          estado_d = ERROR;
          causa_d  = CAUSA_TIMEOUT;
        end
      end

      ESCRITURA: begin
        sel_op1       = op1_x;
        sel_op2       = op2_x;
        sel_inmediato = imm_x;
        modo_alu      = alu_x;
        esc_reg       = 1'b1;
        sel_y         = (op_r == OP_LOAD) ? 2'd1 : 2'd0;
        retirada      = 1'b1;
        estado_d      = BUSQUEDA;
      end

      ERROR: begin
        error = 1'b1;
      end

      default: begin
        estado_d = INICIO;
      end
    endcase
  end

  assign estado             = estado_q;
  assign causa_error        = causa_q;
  assign contador_retiradas = cont_q;

endmodule
